// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state enum,
// opcode constants, control-field encodings and the decoded control bundle.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Per-state control word; pc_write and branch are internal and are
  // combined with Zero in the top to form PcEn.
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle.
//   Op, Zero           : datapath -> controller (opcode, ALU zero flag)
//   IorD .. Illegal    : controller -> datapath control strobes/selects
// master = datapath side, slave = controller side.
interface multicycle_control_if;
  logic [5:0] Op;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [1:0] AluOp;
  logic [1:0] PcSrc;
  logic       PcEn;
  logic       Illegal;

  modport master (
    output Op, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           AluSrcA, AluSrcB, AluOp, PcSrc, PcEn, Illegal
  );

  modport slave (
    input  Op, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           AluSrcA, AluSrcB, AluOp, PcSrc, PcEn, Illegal
  );
endinterface

// File: rtl/mc_output_decode.sv
// Moore output decode: FSM state -> control word. Purely combinational.
//   state : current FSM state
//   ctrl  : control word for that state (unlisted fields are 0)
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JEX: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller (Moore FSM, 12 states).
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-high; forces FETCH (and FETCH outputs)
//   bus   : slave side of multicycle_control_if (Op/Zero in, controls out)
module multicycle_control
  import mips_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  multicycle_control_if.slave   bus
);

  state_t state, next_state;
  ctrl_t  ctrl;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Op is only consulted in DECODE and MEMADR.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = S_MEMWB;
      S_RTYPEEX: next_state = S_RTYPEWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      default:   next_state = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  always_comb begin
    bus.IorD     = ctrl.iord;
    bus.MemWrite = ctrl.mem_write;
    bus.IRWrite  = ctrl.ir_write;
    bus.RegDst   = ctrl.reg_dst;
    bus.MemtoReg = ctrl.mem_to_reg;
    bus.RegWrite = ctrl.reg_write;
    bus.AluSrcA  = ctrl.alu_src_a;
    bus.AluSrcB  = ctrl.alu_src_b;
    bus.AluOp    = ctrl.alu_op;
    bus.PcSrc    = ctrl.pc_src;
    // branch is only set in BEQEX, so Zero has no effect elsewhere
    bus.PcEn     = ctrl.pc_write | (ctrl.branch & bus.Zero);
    bus.Illegal  = (state == S_DECODE) && !op_supported(bus.Op);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control. The stimulus thread
// queues the expected control vector for every cycle (derived from a
// per-instruction cycle table); a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_J     = 6'b000010;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [14:0] exp_q[$];
  string       name_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic int latency(input logic [5:0] op);
    case (op)
      T_LW:                    return 5;
      T_SW, T_RTYPE, T_ADDI:   return 4;
      T_BEQ, T_J:              return 3;
      default:                 return 2;
    endcase
  endfunction

  // Expected outputs for cycle c (1 = FETCH) of instruction op.
  // Vector: {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,AluSrcA,
  //          AluSrcB[2],AluOp[2],PcSrc[2],PcEn,Illegal}
  function automatic logic [14:0] exp_vec(input logic [5:0] op, input int c, input logic z);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen, ill;
    logic [1:0] sb, ao, ps;
    {iord, mw, irw, rd, m2r, rw, sa, pcen, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    if (c == 1) begin
      sb = 2'b01; irw = 1'b1; pcen = 1'b1;
    end else if (c == 2) begin
      sb = 2'b11;
      ill = (latency(op) == 2);
    end else begin
      case (op)
        T_LW, T_SW: begin
          if (c == 3) begin sa = 1'b1; sb = 2'b10; end
          if (c == 4 && op == T_LW) iord = 1'b1;
          if (c == 4 && op == T_SW) begin iord = 1'b1; mw = 1'b1; end
          if (c == 5) begin m2r = 1'b1; rw = 1'b1; end
        end
        T_RTYPE: begin
          if (c == 3) begin sa = 1'b1; ao = 2'b10; end
          if (c == 4) begin rd = 1'b1; rw = 1'b1; end
        end
        T_ADDI: begin
          if (c == 3) begin sa = 1'b1; sb = 2'b10; end
          if (c == 4) rw = 1'b1;
        end
        T_BEQ: begin
          sa = 1'b1; ao = 2'b01; ps = 2'b01; pcen = z;
        end
        T_J: begin
          ps = 2'b10; pcen = 1'b1;
        end
        default: ;
      endcase
    end
    return {iord, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pcen, ill};
  endfunction

  task automatic drive_cycle(input logic [5:0] op, input logic z, input logic rst,
                             input logic [14:0] e, input string nm);
    @(posedge Clk);
    #1;
    bus.Op   = op;
    bus.Zero = z;
    Reset    = rst;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // zf < 0: random Zero; abort_at > 0: pulse Reset in that cycle.
  task automatic run_instr(input logic [5:0] op, input int zf, input int abort_at);
    int n;
    logic [14:0] fetch_v;
    n = latency(op);
    fetch_v = exp_vec(6'd0, 1, 1'b0);
    for (int c = 1; c <= n; c++) begin
      logic [5:0] o;
      logic z;
      // Op carries the instruction only where it is sampled; junk elsewhere.
      o = (c == 2 || c == 3) ? op : 6'($urandom);
      z = (zf < 0) ? 1'($urandom) : zf[0];
      if (c == abort_at) begin
        drive_cycle(o, z, 1'b1, fetch_v, $sformatf("reset_abort_op%b_c%0d", op, c));
        drive_cycle(6'($urandom), 1'($urandom), 1'b1, fetch_v, "reset_hold");
        return;
      end
      drive_cycle(o, z, 1'b0, exp_vec(op, c, z), $sformatf("op%b_c%0d_z%0d", op, c, z));
    end
  endtask

  logic [14:0] mon_exp, mon_act;
  string       mon_name;

  initial begin
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_act  = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                    bus.RegWrite, bus.AluSrcA, bus.AluSrcB, bus.AluOp, bus.PcSrc,
                    bus.PcEn, bus.Illegal};
        n_checks++;
        if (mon_act === mon_exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", mon_name, mon_act, mon_exp);
      end
    end
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    int ab;
    ops[0] = T_RTYPE; ops[1] = T_LW; ops[2] = T_SW;
    ops[3] = T_BEQ;   ops[4] = T_ADDI; ops[5] = T_J;
    bus.Op   = 6'd0;
    bus.Zero = 1'b0;
    Reset    = 1'b1;

    drive_cycle(6'd0, 1'b0, 1'b1, exp_vec(6'd0, 1, 1'b0), "in_reset_0");
    drive_cycle(6'd35, 1'b1, 1'b1, exp_vec(6'd0, 1, 1'b0), "in_reset_1");

    run_instr(T_LW, -1, 4);     // reset during MEMRD
    run_instr(T_LW, -1, 0);
    run_instr(T_SW, -1, 0);
    run_instr(T_RTYPE, -1, 0);
    run_instr(T_BEQ, 1, 0);
    run_instr(T_BEQ, 0, 0);
    run_instr(6'b111111, -1, 0);
    run_instr(T_J, -1, 0);
    run_instr(T_ADDI, -1, 0);

    repeat (80) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, latency(op))) : 0;
      run_instr(op, -1, ab);
    end

    repeat (3) @(negedge Clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
